ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: port0 always wins a tie and no last-grant pointer exists.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no access in flight; requests sampled at each edge
// ST_WR    | single write cycle, bus driven with latched write data
// ST_RD1   | read address presented, RAM loads its output register
// ST_RD2   | RAM data on the bus, captured into rdata at cycle end
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD1  = 2'd2;
    localparam logic [1:0] ST_RD2  = 2'd3;

    logic [1:0]        state;
    logic              op_port;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              any_req;
    logic              pick1;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign any_req = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign pick1 = req1 & ~req0;
`else
    // last_p1 = 1 means port1 was granted last, so port0 wins the next tie
    logic last_p1;

    assign pick1 = req1 & (~req0 | ~last_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_p1 <= 1'b1;
        end else if (state == ST_IDLE && any_req) begin
            last_p1 <= pick1;
        end
    end
`endif

    assign win_we    = pick1 ? we1    : we0;
    assign win_addr  = pick1 ? addr1  : addr0;
    assign win_wdata = pick1 ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_port <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        op_port <= pick1;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        gnt0    <= ~pick1;
                        gnt1    <= pick1;
                        state   <= win_we ? ST_WR : ST_RD1;
                    end
                end
                ST_WR: begin
                    state <= ST_IDLE;
                end
                ST_RD1: begin
                    state <= ST_RD2;
                end
                ST_RD2: begin
                    state <= ST_IDLE;
                    if (op_port) begin
                        rdata1  <= ram_data;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_data;
                        rvalid0 <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM strobes decode straight from the state register
    assign busy     = (state != ST_IDLE);
    assign ram_cs   = busy;
    assign ram_wr   = (state == ST_WR);
    assign ram_rd   = (state == ST_RD1) || (state == ST_RD2);
    assign ram_addr = addr_q;
    assign ram_data = ram_wr ? wdata_q : {DATA_W{1'bz}};

endmodule
